// File: rtl/id_ex_pipe.sv
// Decode stage and ID/EX pipeline register: decodes the IF/ID word, detects load-use hazards, honours EX flushes.
// Optional macro ID_EX_STALL_CNT_EN adds a saturating stall_cnt output.
module id_ex_pipe #(
    parameter int unsigned DW   = 32,
    parameter int unsigned NREG = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [31:0]   id_instr,
    input  logic [DW-1:0] id_pc,
    input  logic          flush,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic          enable_ab,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    output logic          stall,
    output logic          ex_valid,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rd,
    output logic [2:0]    ex_alu_op,
    output logic          ex_alu_src_imm,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_branch,
    output logic [DW-1:0] ex_pc,
    output logic          illegal
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [5:0] NREG_L = 6'(NREG);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rd_field;
    logic       d_legal;
    logic       d_ok;
    logic [2:0] d_op;
    logic       d_src;
    logic       d_rw;
    logic       d_mr;
    logic       d_mw;
    logic       d_br;
    logic [4:0] d_rd;
    logic       use_rs;
    logic       use_rt;
    logic       idx_ok;
    logic       hz;
    logic       capture;
    logic       load;
    logic       unused_shamt;

    assign opcode       = id_instr[31:26];
    assign funct        = id_instr[5:0];
    assign rd_field     = id_instr[15:11];
    assign rs           = id_instr[25:21];
    assign rt           = id_instr[20:16];
    assign unused_shamt = ^id_instr[10:6];

    always_comb begin
        d_legal = 1'b1;
        d_op    = ALU_ADD;
        d_src   = 1'b0;
        d_rw    = 1'b0;
        d_mr    = 1'b0;
        d_mw    = 1'b0;
        d_br    = 1'b0;
        d_rd    = '0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                d_rd   = rd_field;
                d_rw   = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
                case (funct)
                    FN_ADD:  d_op = ALU_ADD;
                    FN_SUB:  d_op = ALU_SUB;
                    FN_AND:  d_op = ALU_AND;
                    FN_OR:   d_op = ALU_OR;
                    FN_SLT:  d_op = ALU_SLT;
                    default: d_legal = 1'b0;
                endcase
            end
            OP_LW: begin
                d_rd   = rt;
                d_src  = 1'b1;
                d_mr   = 1'b1;
                d_rw   = 1'b1;
                use_rs = 1'b1;
            end
            OP_SW: begin
                d_src  = 1'b1;
                d_mw   = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_ADDI: begin
                d_rd   = rt;
                d_src  = 1'b1;
                d_rw   = 1'b1;
                use_rs = 1'b1;
            end
            OP_BEQ: begin
                d_op   = ALU_SUB;
                d_br   = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            default: d_legal = 1'b0;
        endcase
        if (d_rd == 5'd0) begin
            d_rw = 1'b0;
        end
    end

    // rs/rt are checked for every format (rt is the destination of LW/ADDI); rd only for R-type.
    assign idx_ok = ({1'b0, rs} < NREG_L) && ({1'b0, rt} < NREG_L) &&
                    ((opcode != OP_RTYPE) || ({1'b0, rd_field} < NREG_L));
    assign d_ok   = d_legal & idx_ok;

    assign hz = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                ((use_rs & (ex_rd == rs)) | (use_rt & (ex_rd == rt)));

    assign stall     = hz & ~flush;
    assign enable_ab = id_valid & ~flush;
    assign capture   = id_valid & ~flush & ~hz;
    assign load      = capture & d_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_a           <= '0;
            ex_b           <= '0;
            ex_imm         <= '0;
            ex_rd          <= '0;
            ex_alu_op      <= '0;
            ex_alu_src_imm <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_branch      <= 1'b0;
            ex_pc          <= '0;
            illegal        <= 1'b0;
        end else begin
            ex_a           <= A;
            ex_b           <= B;
            ex_imm         <= {{(DW-16){id_instr[15]}}, id_instr[15:0]};
            ex_pc          <= id_pc;
            ex_valid       <= load;
            ex_rd          <= load ? d_rd  : '0;
            ex_alu_op      <= load ? d_op  : '0;
            ex_alu_src_imm <= load & d_src;
            ex_reg_write   <= load & d_rw;
            ex_mem_read    <= load & d_mr;
            ex_mem_write   <= load & d_mw;
            ex_branch      <= load & d_br;
            if (capture && !d_ok) begin
                illegal <= 1'b1;
            end
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
